// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array sequencer: state encoding,
// operand width, default array size and step-counter sizing.
package tpu_pkg;

    localparam int DATA_W    = 8;
    localparam int N_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Step counter must reach 2N-2 during FEED.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/systolic_seq_operand_buf.sv
// N*N x DW operand register file: one synchronous write port and N
// independent combinational read ports (one per array edge lane).
module operand_buf
    import tpu_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DATA_W,
    parameter int AW = $clog2(N * N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [N*AW-1:0] rd_addr,
    output logic [N*DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [N*N];
    logic [DW-1:0] mem_d [N*N];

    // Next-state of every entry: write hits only the addressed element.
    always_comb begin
        for (int e = 0; e < N * N; e++) begin
            if (wr_en && (wr_addr == AW'(e))) begin
                mem_d[e] = wr_data;
            end else begin
                mem_d[e] = mem_q[e];
            end
        end
    end

    // Storage array, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < N * N; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < N * N; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

    // Parallel read ports; addresses past N*N-1 read as zero.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < N; p++) begin
            if (int'(rd_addr[p*AW +: AW]) < N * N) begin
                rd_data[p*DW +: DW] = mem_q[rd_addr[p*AW +: AW]];
            end else begin
                rd_data[p*DW +: DW] = '0;
            end
        end
    end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer for an NxN output-stationary systolic array: clears the PEs,
// streams skewed A rows / B columns into the array edges, drains, reports done.
module systolic_seq
    import tpu_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DATA_W,
    parameter int AW = $clog2(N * N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            busy,
    output logic            done,
    output logic            pe_clear,
    output logic [N*DW-1:0] a_feed,
    output logic [N*DW-1:0] b_feed
);

    localparam int CW = cnt_width(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_ok_s, a_we_s, b_we_s;
    logic [N-1:0]    skew_vld_s;
    logic [N*AW-1:0] a_raddr_s, b_raddr_s;
    logic [N*DW-1:0] a_rdata_s, b_rdata_s;
    logic            busy_q, busy_d, done_q, done_d, pe_clear_q, pe_clear_d;
    logic [N*DW-1:0] a_feed_q, a_feed_d, b_feed_q, b_feed_d;

    assign wr_ok_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign a_we_s  = wr_en && wr_ok_s && !wr_sel;
    assign b_we_s  = wr_en && wr_ok_s && wr_sel;

    operand_buf #(.N(N), .DW(DW), .AW(AW)) u_a_buf (
        .clk(clk), .rst(rst), .wr_en(a_we_s), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(a_raddr_s), .rd_data(a_rdata_s)
    );

    operand_buf #(.N(N), .DW(DW), .AW(AW)) u_b_buf (
        .clk(clk), .rst(rst), .wr_en(b_we_s), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(b_raddr_s), .rd_data(b_rdata_s)
    );

    // Next-state and step-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                cnt_d   = '0;
            end
            ST_FEED: begin
                if (cnt_q == CW'(2 * N - 2)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Skew addressing for the step being entered; lane i serves A row i and B column i.
    always_comb begin
        skew_vld_s = '0;
        a_raddr_s  = '0;
        b_raddr_s  = '0;
        for (int i = 0; i < N; i++) begin
            if ((state_d == ST_FEED) && (int'(cnt_d) >= i) && (int'(cnt_d) - i < N)) begin
                skew_vld_s[i]         = 1'b1;
                a_raddr_s[i*AW +: AW] = AW'(i * N + int'(cnt_d) - i);
                b_raddr_s[i*AW +: AW] = AW'((int'(cnt_d) - i) * N + i);
            end else begin
                skew_vld_s[i] = 1'b0;
            end
        end
    end

    // Output decode from the next state so each registered output lines up with its state.
    always_comb begin
        busy_d     = (state_d == ST_CLEAR) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        pe_clear_d = (state_d == ST_CLEAR);
        a_feed_d   = '0;
        b_feed_d   = '0;
        for (int i = 0; i < N; i++) begin
            if (skew_vld_s[i]) begin
                a_feed_d[i*DW +: DW] = a_rdata_s[i*DW +: DW];
                b_feed_d[i*DW +: DW] = b_rdata_s[i*DW +: DW];
            end else begin
                a_feed_d[i*DW +: DW] = '0;
                b_feed_d[i*DW +: DW] = '0;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pe_clear_q <= 1'b0;
            a_feed_q   <= '0;
            b_feed_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pe_clear_q <= pe_clear_d;
            a_feed_q   <= a_feed_d;
            b_feed_q   <= b_feed_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pe_clear = pe_clear_q;
    assign a_feed   = a_feed_q;
    assign b_feed   = b_feed_q;

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: drives a 2x2 PE grid from the feeds and compares
// against matrix-level expectations (skew rule, timing, C = A*B mod 256).
module tb_systolic_seq;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = $clog2(N * N);

    logic            clk, rst, start, wr_en, wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            busy, done, pe_clear;
    logic [N*DW-1:0] a_feed, b_feed;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0]   mat_a [N][N];
    logic [DW-1:0]   mat_b [N][N];
    logic [DW-1:0]   c_snap [N][N];
    logic            cap_clear [48];
    logic            cap_busy [48];
    logic            cap_done [48];
    logic [N*DW-1:0] cap_a [48];
    logic [N*DW-1:0] cap_b [48];
    int              done_cyc;

    systolic_seq #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .pe_clear(pe_clear), .a_feed(a_feed), .b_feed(b_feed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Harness PE grid: registered a/b pass-through, 8-bit wrapping accumulator.
    logic [DW-1:0] pa_q [N][N];
    logic [DW-1:0] pb_q [N][N];
    logic [DW-1:0] pc_q [N][N];
    logic [DW-1:0] pe_a_s [N][N];
    logic [DW-1:0] pe_b_s [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pe_a_s[i][0] = a_feed[i*DW +: DW];
            pe_b_s[0][i] = b_feed[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
                pe_a_s[i][j] = pa_q[i][j-1];
                pe_b_s[j][i] = pb_q[j-1][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst) begin
                    pa_q[i][j] <= '0;
                    pb_q[i][j] <= '0;
                    pc_q[i][j] <= '0;
                end else begin
                    pa_q[i][j] <= pe_a_s[i][j];
                    pb_q[i][j] <= pe_b_s[i][j];
                    pc_q[i][j] <= pe_clear ? 8'd0 : DW'(pc_q[i][j] + pe_a_s[i][j] * pe_b_s[i][j]);
                end
            end
        end
    end

    // Reference: feed value for run cycle c (cycle 1 = CLEAR, FEED step k = c-2).
    function automatic logic [N*DW-1:0] exp_a(input int c);
        logic [N*DW-1:0] v;
        int k;
        v = '0;
        k = c - 2;
        if (k >= 0 && k <= 2 * N - 2)
            for (int i = 0; i < N; i++)
                if (k - i >= 0 && k - i < N) v[i*DW +: DW] = mat_a[i][k-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int c);
        logic [N*DW-1:0] v;
        int k;
        v = '0;
        k = c - 2;
        if (k >= 0 && k <= 2 * N - 2)
            for (int j = 0; j < N; j++)
                if (k - j >= 0 && k - j < N) v[j*DW +: DW] = mat_b[k-j][j];
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_c(input int i, input int j);
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(mat_a[i][k]) * int'(mat_b[k][j]);
        return acc[DW-1:0];
    endfunction

    task automatic write_elem(input logic sel, input int idx, input logic [DW-1:0] val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(idx);
        wr_data = val;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                write_elem(1'b0, i * N + j, mat_a[i][j]);
                write_elem(1'b1, i * N + j, mat_b[i][j]);
            end
    endtask

    // Start one run (optionally writing in the start cycle) and record outputs per cycle until done.
    task automatic run_capture(input bit wr_too, input logic sel, input int idx, input logic [DW-1:0] val);
        @(negedge clk);
        start = 1'b1;
        if (wr_too) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_addr = AW'(idx);
            wr_data = val;
        end
        @(negedge clk);
        start    = 1'b0;
        wr_en    = 1'b0;
        done_cyc = -1;
        for (int c = 1; c < 48; c++) begin
            cap_clear[c] = pe_clear;
            cap_busy[c]  = busy;
            cap_done[c]  = done;
            cap_a[c]     = a_feed;
            cap_b[c]     = b_feed;
            if (done === 1'b1) begin
                done_cyc = c;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) c_snap[i][j] = pc_q[i][j];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, pe_clear, a_feed, b_feed} !== '0) begin
            $display("FAIL reset_hold outputs=%h required 0", {busy, done, pe_clear, a_feed, b_feed});
            tests_failed++;
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, done, pe_clear, a_feed, b_feed} !== '0) begin
            $display("FAIL reset_release outputs=%h required 0", {busy, done, pe_clear, a_feed, b_feed});
            tests_failed++;
        end
        run_capture(1'b0, 1'b0, 0, 8'd0);
        tests_run++;
        if (done_cyc != 3 * N + 1) begin
            $display("FAIL reset_run_done cycle=%0d required %0d", done_cyc, 3 * N + 1);
            tests_failed++;
        end
        for (int c = 1; c <= 3 * N + 1; c++) begin
            tests_run++;
            if ({cap_a[c], cap_b[c]} !== '0) begin
                $display("FAIL reset_run_feeds c=%0d got %h required 0", c, {cap_a[c], cap_b[c]});
                tests_failed++;
            end
        end
    endtask

    task automatic test_skew();
        logic [DW-1:0] ca [N][N];
        ca = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
        mat_a = ca;
        ca = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
        mat_b = ca;
        load_all();
        run_capture(1'b0, 1'b0, 0, 8'd0);
        tests_run++;
        if (done_cyc != 3 * N + 1) begin
            $display("FAIL skew_done cycle=%0d required %0d", done_cyc, 3 * N + 1);
            tests_failed++;
        end
        for (int c = 1; c <= 3 * N + 1; c++) begin
            tests_run++;
            if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c) || cap_clear[c] !== (c == 1)
                || cap_busy[c] !== (c <= 3 * N) || cap_done[c] !== (c == 3 * N + 1)) begin
                $display("FAIL skew_cycle c=%0d got a=%h b=%h clr=%b busy=%b done=%b required a=%h b=%h clr=%b busy=%b done=%b",
                         c, cap_a[c], cap_b[c], cap_clear[c], cap_busy[c], cap_done[c],
                         exp_a(c), exp_b(c), c == 1, c <= 3 * N, c == 3 * N + 1);
                tests_failed++;
            end
        end
    endtask

    task automatic test_integration();
        logic [DW-1:0] want [4];
        want = '{8'd19, 8'd22, 8'd43, 8'd50};
        run_capture(1'b0, 1'b0, 0, 8'd0);
        for (int p = 0; p < 4; p++) begin
            tests_run++;
            if (c_snap[p / 2][p % 2] !== want[p] || done_cyc < 0) begin
                $display("FAIL integ_c pe=%0d got %0d required %0d (done_cyc=%0d)", p, c_snap[p / 2][p % 2], want[p], done_cyc);
                tests_failed++;
            end
        end
    endtask

    task automatic test_write_busy();
        int seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd9;
        @(negedge clk);
        wr_en = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (seen == 0 || pc_q[0][0] !== 8'd19) begin
            $display("FAIL busy_write_run1 c00=%0d required 19 (done seen=%0d)", pc_q[0][0], seen);
            tests_failed++;
        end
        run_capture(1'b0, 1'b0, 0, 8'd0);
        tests_run++;
        if (c_snap[0][0] !== 8'd19 || cap_a[2] !== exp_a(2)) begin
            $display("FAIL busy_write_run2 c00=%0d a_k0=%h required 19 / %h", c_snap[0][0], cap_a[2], exp_a(2));
            tests_failed++;
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, pe_clear, a_feed, b_feed} !== '0) begin
            $display("FAIL midrun_reset outputs=%h required 0", {busy, done, pe_clear, a_feed, b_feed});
            tests_failed++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = '0;
                mat_b[i][j] = '0;
            end
        run_capture(1'b0, 1'b0, 0, 8'd0);
        tests_run++;
        if (done_cyc != 3 * N + 1 || cap_a[2] !== '0 || cap_b[2] !== '0 || cap_a[3] !== '0 || cap_b[3] !== '0) begin
            $display("FAIL midrun_cleared done=%0d a=%h/%h b=%h/%h required %0d and zero feeds",
                     done_cyc, cap_a[2], cap_a[3], cap_b[2], cap_b[3], 3 * N + 1);
            tests_failed++;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = DW'($urandom_range(0, 255));
                mat_b[i][j] = DW'($urandom_range(0, 255));
            end
        load_all();
        run_capture(1'b0, 1'b0, 0, 8'd0);
        for (int p = 0; p < N * N; p++) begin
            tests_run++;
            if (c_snap[p / N][p % N] !== exp_c(p / N, p % N) || done_cyc != 3 * N + 1) begin
                $display("FAIL midrun_rerun pe=%0d got %0d required %0d", p, c_snap[p / N][p % N], exp_c(p / N, p % N));
                tests_failed++;
            end
        end
    endtask

    task automatic test_random();
        int idx;
        logic [DW-1:0] v;
        for (int it = 0; it < 4; it++) begin
            idx = $urandom_range(0, N * N - 1);
            v   = DW'($urandom_range(0, 255));
            mat_a[idx / N][idx % N] = v;
            run_capture(1'b1, 1'b0, idx, v);
            for (int c = 1; c <= 3 * N + 1; c++) begin
                tests_run++;
                if (cap_a[c] !== exp_a(c) || cap_b[c] !== exp_b(c)) begin
                    $display("FAIL rand_feed it=%0d c=%0d got %h/%h required %h/%h", it, c, cap_a[c], cap_b[c], exp_a(c), exp_b(c));
                    tests_failed++;
                end
            end
            for (int p = 0; p < N * N; p++) begin
                tests_run++;
                if (c_snap[p / N][p % N] !== exp_c(p / N, p % N)) begin
                    $display("FAIL rand_c it=%0d pe=%0d got %0d required %0d", it, p, c_snap[p / N][p % N], exp_c(p / N, p % N));
                    tests_failed++;
                end
            end
            // Still in the DONE cycle: this B write must be accepted.
            idx = $urandom_range(0, N * N - 1);
            v   = DW'($urandom_range(0, 255));
            mat_b[idx / N][idx % N] = v;
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = AW'(idx); wr_data = v;
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int dpos [$];
        int prev_done;
        @(negedge clk);
        start = 1'b1;
        prev_done = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dpos.push_back(c);
                tests_run++;
                if (prev_done == 1) begin
                    $display("FAIL b2b_pulse_width c=%0d done high two cycles", c);
                    tests_failed++;
                end
            end
            prev_done = (done === 1'b1) ? 1 : 0;
            if (c == 24) start = 1'b0;
        end
        tests_run++;
        if (dpos.size() != 3) begin
            $display("FAIL b2b_count got %0d pulses required 3", dpos.size());
            tests_failed++;
        end else begin
            for (int p = 0; p < 3; p++) begin
                tests_run++;
                if (dpos[p] != 3 * N + 1 + p * (3 * N + 2)) begin
                    $display("FAIL b2b_pos pulse=%0d got cycle %0d required %0d", p, dpos[p], 3 * N + 1 + p * (3 * N + 2));
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            $display("FAIL b2b_idle busy=%b required 0", busy);
            tests_failed++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = '0;
                mat_b[i][j] = '0;
            end
        test_reset();
        test_skew();
        test_integration();
        test_write_busy();
        test_midrun_reset();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
